// File: rtl/turn_signal_seq.sv
// Tail-light sequencer for left, right and hazard signalling with LAMPS lamps per side.
// Optional `BRAKE_EN` adds a brake input that forces the non-sequencing side(s) on.
module turn_signal_seq #(
  parameter int LAMPS = 3,
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
`ifdef BRAKE_EN
  input  logic             brake,
`endif
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic             tick,
  output logic             busy
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(LAMPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [SW-1:0]    step, step_n;
  logic [SW-1:0]    step_inc;
  logic [LAMPS-1:0] lamp_l_q, lamp_l_n;
  logic [LAMPS-1:0] lamp_r_q, lamp_r_n;
  logic [DIV_W-1:0] div_cnt;
  logic             req_hz, req_l, req_r;

  // Free-running divider; the all-ones count is the one-cycle enable.
  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= div_cnt + 1'b1;
  end

  assign tick = &div_cnt;

  assign req_hz = hazard | (left & right);
  assign req_l  = left & ~req_hz;
  assign req_r  = right & ~req_hz;

  assign step_inc = step + 1'b1;

  // Thermometer fill: the low n lamps lit, starting from the inboard end.
  function automatic logic [LAMPS-1:0] fill(input logic [SW-1:0] n);
    logic [LAMPS-1:0] f;
    for (int i = 0; i < LAMPS; i++) f[i] = (int'(n) > i);
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      lamp_l_q <= '0;
      lamp_r_q <= '0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      lamp_l_q <= lamp_l_n;
      lamp_r_q <= lamp_r_n;
    end
  end

  always_comb begin
    state_n  = state;
    step_n   = step;
    lamp_l_n = lamp_l_q;
    lamp_r_n = lamp_r_q;
    if (tick) begin
      case (state)
        IDLE: begin
          lamp_l_n = '0;
          lamp_r_n = '0;
          if (req_hz) begin
            state_n  = HAZ;
            step_n   = '0;
            lamp_l_n = '1;
            lamp_r_n = '1;
          end else if (req_l) begin
            state_n  = LEFT;
            step_n   = SW'(1);
            lamp_l_n = fill(SW'(1));
          end else if (req_r) begin
            state_n  = RIGHT;
            step_n   = SW'(1);
            lamp_r_n = fill(SW'(1));
          end
        end
        LEFT, RIGHT: begin
          if (req_hz) begin
            state_n  = HAZ;
            step_n   = '0;
            lamp_l_n = '1;
            lamp_r_n = '1;
          end else if (step < LAST_STEP) begin
            step_n   = step_inc;
            lamp_l_n = (state == LEFT)  ? fill(step_inc) : '0;
            lamp_r_n = (state == RIGHT) ? fill(step_inc) : '0;
          end else begin
            state_n  = IDLE;
            step_n   = '0;
            lamp_l_n = '0;
            lamp_r_n = '0;
          end
        end
        default: begin
          state_n  = IDLE;
          step_n   = '0;
          lamp_l_n = '0;
          lamp_r_n = '0;
        end
      endcase
    end
  end

  // Brake overlays the registered pattern combinationally, independent of tick.
  always_comb begin
    busy   = (state != IDLE);
    lamp_l = lamp_l_q;
    lamp_r = lamp_r_q;
`ifdef BRAKE_EN
    if (brake && (state == IDLE || state == RIGHT)) lamp_l = '1;
    if (brake && (state == IDLE || state == LEFT))  lamp_r = '1;
`endif
  end

endmodule
